// File: rtl/dlx_mc_ctrl_gen_if.sv
// Controller-to-datapath bundle: decoder inputs, memory handshakes and datapath enables.
// master = controller side, slave = decoder/datapath/memory side.
interface dlx_mc_ctrl_gen_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                condition;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                dmem_req;
    logic                enable_I;
    logic                enable_PC;
    logic                sel_inc;
    logic                load_new_PC;
    logic                link;
    logic                enable_reg;
    logic                read_word;
    logic                enable_write;
    logic                instr_retired;
    logic                mem_error;
    logic [2:0]          state_o;

    modport master (
        input  opcode, condition, imem_ready, dmem_ready,
        output imem_req, dmem_req, enable_I, enable_PC, sel_inc, load_new_PC, link,
               enable_reg, read_word, enable_write, instr_retired, mem_error, state_o
    );

    modport slave (
        output opcode, condition, imem_ready, dmem_ready,
        input  imem_req, dmem_req, enable_I, enable_PC, sel_inc, load_new_PC, link,
               enable_reg, read_word, enable_write, instr_retired, mem_error, state_o
    );
endinterface

// File: rtl/dlx_mc_ctrl_gen.sv
// Multicycle DLX controller: IF/ID/EX/MEM/WB sequencer with ready handshakes and a sticky timeout ERR state.
// Mealy outputs; optional retired-instruction counter enabled by defining DLX_PERF_CNT_EN.
module dlx_mc_ctrl_gen #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int SKIP_STATES = 1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    dlx_mc_ctrl_gen_if.master   bus
`ifdef DLX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    retired_count
`endif
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    typedef struct packed {
        logic imem_req;
        logic dmem_req;
        logic enable_I;
        logic enable_PC;
        logic sel_inc;
        logic load_new_PC;
        logic link;
        logic enable_reg;
        logic read_word;
        logic enable_write;
        logic instr_retired;
        logic mem_error;
    } ctl_t;

    localparam int            TW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(MEM_TIMEOUT);

    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'h03);
    localparam logic [OPCODE_W-1:0] OP_BEQZ = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_BENZ = OPCODE_W'(6'h05);
    localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(6'h12);
    localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(6'h13);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    ctl_t          ctl, ctl_o;
    logic          waiting;

    logic is_jr, is_link, is_jump, is_br, is_lw, is_sw, is_mem;
    assign is_jr   = (bus.opcode == OP_JR)  || (bus.opcode == OP_JALR);
    assign is_link = (bus.opcode == OP_JAL) || (bus.opcode == OP_JALR);
    assign is_jump = is_jr || is_link || (bus.opcode == OP_J);
    assign is_br   = (bus.opcode == OP_BEQZ) || (bus.opcode == OP_BENZ);
    assign is_lw   = (bus.opcode == OP_LW);
    assign is_sw   = (bus.opcode == OP_SW);
    assign is_mem  = is_lw || is_sw;

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        waiting = 1'b0;
        case (state_q)
            S_IF: begin
                ctl.imem_req = 1'b1;
                ctl.sel_inc  = 1'b1;
                if (bus.imem_ready) begin
                    ctl.enable_I  = 1'b1;
                    ctl.enable_PC = 1'b1;
                    state_d       = S_ID;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_ID: state_d = S_EX;
            S_EX: begin
                ctl.enable_PC   = is_jump || (is_br && bus.condition);
                ctl.load_new_PC = is_jr;
                ctl.link        = is_link;
                ctl.enable_reg  = is_link;
                if (is_mem || SKIP_STATES == 0) state_d = S_MEM;
                else if (is_jump || is_br)      state_d = S_IF;
                else                            state_d = S_WB;
            end
            S_MEM: begin
                if (is_mem) begin
                    ctl.dmem_req     = 1'b1;
                    ctl.enable_write = is_sw;
                    if (bus.dmem_ready) state_d = (is_sw && SKIP_STATES != 0) ? S_IF : S_WB;
                    else                waiting = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                ctl.enable_reg = !is_sw;
                ctl.read_word  = is_lw;
                state_d        = S_IF;
            end
            S_ERR:   ctl.mem_error = 1'b1;
            default: state_d = S_ERR;
        endcase

        // Ready arriving on the deadline cycle has already advanced state_d, so it wins.
        if (waiting && MEM_TIMEOUT != 0 && cnt_q == T_MAX) state_d = S_ERR;

        cnt_d = cnt_q;
        if (state_d != state_q)          cnt_d = '0;
        else if (waiting && cnt_q != T_MAX) cnt_d = cnt_q + 1'b1;

        ctl.instr_retired = (state_q != S_IF) && (state_q != S_ERR) && (state_d == S_IF);
        ctl_o = reset ? '0 : ctl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_req      = ctl_o.imem_req;
    assign bus.dmem_req      = ctl_o.dmem_req;
    assign bus.enable_I      = ctl_o.enable_I;
    assign bus.enable_PC     = ctl_o.enable_PC;
    assign bus.sel_inc       = ctl_o.sel_inc;
    assign bus.load_new_PC   = ctl_o.load_new_PC;
    assign bus.link          = ctl_o.link;
    assign bus.enable_reg    = ctl_o.enable_reg;
    assign bus.read_word     = ctl_o.read_word;
    assign bus.enable_write  = ctl_o.enable_write;
    assign bus.instr_retired = ctl_o.instr_retired;
    assign bus.mem_error     = ctl_o.mem_error;
    assign bus.state_o       = reset ? 3'd0 : state_q;

`ifdef DLX_PERF_CNT_EN
    logic [CNT_W-1:0] retired_count_q, retired_count_d;

    always_comb begin
        retired_count_d = retired_count_q;
        if (ctl_o.instr_retired) retired_count_d = retired_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) retired_count_q <= '0;
        else       retired_count_q <= retired_count_d;
    end

    assign retired_count = retired_count_q;
`endif
endmodule

// File: tb/tb_dlx_mc_ctrl_gen.sv
// Self-checking bench for dlx_mc_ctrl_gen: directed scenarios plus a randomized instruction stream.
// Expected per-cycle outputs come from an instruction-level phase model (IF waits, ID, EX, MEM waits, WB).
module tb_dlx_mc_ctrl_gen;
    localparam int OW = 6;
    localparam int TO = 4;

    localparam logic [5:0] ADD = 6'h00, BEQZ = 6'h04, BENZ = 6'h05, J = 6'h02, JAL = 6'h03;
    localparam logic [5:0] JALR = 6'h13, JR = 6'h12, SW = 6'h2B, LW = 6'h23;

    // expected-vector bit positions
    localparam int B_IREQ = 11, B_DREQ = 10, B_EI = 9, B_EPC = 8, B_INC = 7, B_LNP = 6;
    localparam int B_LINK = 5, B_EREG = 4, B_RW = 3, B_EW = 2, B_RET = 1, B_ERR = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dlx_mc_ctrl_gen_if #(.OPCODE_W(OW)) bus ();

`ifdef DLX_PERF_CNT_EN
    logic [7:0] retired_count;
`endif

    dlx_mc_ctrl_gen #(
        .OPCODE_W(OW), .MEM_TIMEOUT(TO), .SKIP_STATES(1), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DLX_PERF_CNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    function automatic logic [11:0] obs();
        return {bus.imem_req, bus.dmem_req, bus.enable_I, bus.enable_PC, bus.sel_inc,
                bus.load_new_PC, bus.link, bus.enable_reg, bus.read_word, bus.enable_write,
                bus.instr_retired, bus.mem_error};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Entered just after a rising edge; drives one cycle, checks mid-cycle, exits just after the next edge.
    task automatic step(input logic ir, input logic dr, input logic rst,
                        input logic [11:0] ev, input logic [2:0] es, input string tag);
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        reset          = rst;
        @(negedge clk);
        n_tests++;
        if (obs() !== ev || bus.state_o !== es) begin
            n_fail++;
            $display("FAIL %s: outputs=%03h state=%0d, expected outputs=%03h state=%0d",
                     tag, obs(), bus.state_o, ev, es);
        end
        if (rst)          exp_cnt = 0;
        else if (ev[B_RET]) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
`ifdef DLX_PERF_CNT_EN
        n_tests++;
        if (retired_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s: retired_count=%0d expected %0d", tag, retired_count, 8'(exp_cnt));
        end
`endif
    endtask

    // One instruction: wi/wm = cycles of ready low in IF/MEM; abort_at = MEM cycle to assert reset (-1 none).
    task automatic exec_instr(input logic [5:0] op, input logic cond, input int wi, input int wm,
                              input int abort_at, output bit errored, input string tag);
        logic [11:0] e;
        bit jmp, br, lnk, jr, lw, sw, mem, last, rdy;
        errored = 0;
        bus.opcode    = op;
        bus.condition = cond;
        jr  = (op == JR) || (op == JALR);
        lnk = (op == JAL) || (op == JALR);
        jmp = jr || lnk || (op == J);
        br  = (op == BEQZ) || (op == BENZ);
        lw  = (op == LW);
        sw  = (op == SW);
        mem = lw || sw;

        for (int i = 0; i <= TO; i++) begin
            rdy = (i == wi);
            e = '0; e[B_IREQ] = 1; e[B_INC] = 1; e[B_EI] = rdy; e[B_EPC] = rdy;
            step(rdy, rbit(), 0, e, 3'd0, {tag, " IF"});
            if (rdy) break;
            if (i == TO) begin errored = 1; return; end
        end

        step(rbit(), rbit(), 0, 12'h000, 3'd1, {tag, " ID"});

        last = !mem && (jmp || br);
        e = '0; e[B_EPC] = jmp || (br && cond); e[B_LNP] = jr; e[B_LINK] = lnk;
        e[B_EREG] = lnk; e[B_RET] = last;
        step(rbit(), rbit(), 0, e, 3'd2, {tag, " EX"});
        if (last) return;

        if (mem) begin
            for (int i = 0; i <= TO; i++) begin
                if (i == abort_at) begin
                    step(rbit(), rbit(), 1, 12'h000, 3'd0, {tag, " MEM abort"});
                    return;
                end
                rdy = (i == wm);
                e = '0; e[B_DREQ] = 1; e[B_EW] = sw; e[B_RET] = rdy && sw;
                step(rbit(), rdy, 0, e, 3'd3, {tag, " MEM"});
                if (rdy) break;
                if (i == TO) begin errored = 1; return; end
            end
            if (sw) return;
        end

        e = '0; e[B_EREG] = 1; e[B_RW] = lw; e[B_RET] = 1;
        step(rbit(), rbit(), 0, e, 3'd4, {tag, " WB"});
    endtask

    task automatic check_err(input int n, input string tag);
        for (int i = 0; i < n; i++) step(rbit(), rbit(), 0, 12'h001, 3'd5, tag);
    endtask

    task automatic test_reset();
        bus.opcode = SW;
        bus.condition = 1;
        step(1, 1, 1, 12'h000, 3'd0, "reset held");
        step(1, 1, 1, 12'h000, 3'd0, "reset held 2");
        check_count("reset count");
    endtask

    task automatic test_add();
        bit er;
        exec_instr(ADD, 0, 0, 0, -1, er, "add");
        exec_instr(ADD, 1, 2, 0, -1, er, "add ifwait");
    endtask

    task automatic test_lw_stall();
        bit er;
        exec_instr(LW, 0, 0, 3, -1, er, "lw stall");
    endtask

    task automatic test_branch();
        bit er;
        exec_instr(BEQZ, 0, 0, 0, -1, er, "beqz c0");
        exec_instr(BEQZ, 1, 0, 0, -1, er, "beqz c1");
        exec_instr(BENZ, 1, 1, 0, -1, er, "benz c1");
    endtask

    task automatic test_jumps();
        bit er;
        exec_instr(JALR, 0, 0, 0, -1, er, "jalr");
        exec_instr(JR,   1, 0, 0, -1, er, "jr");
        exec_instr(JAL,  0, 0, 0, -1, er, "jal");
        exec_instr(J,    0, 0, 0, -1, er, "j");
    endtask

    task automatic test_timeout();
        bit er;
        exec_instr(SW, 0, 0, 100, -1, er, "sw timeout");
        check_err(3, "sw err sticky");
        step(0, 0, 1, 12'h000, 3'd0, "err reset");
        exec_instr(SW, 0, 0, TO, -1, er, "sw ready at deadline");
        exec_instr(ADD, 0, 100, 0, -1, er, "if timeout");
        check_err(2, "if err sticky");
        step(0, 0, 1, 12'h000, 3'd0, "err reset 2");
        exec_instr(ADD, 0, TO, 0, -1, er, "if ready at deadline");
        check_count("count after timeouts");
    endtask

    task automatic test_reset_mid();
        bit er;
        exec_instr(LW, 0, 0, 0, -1, er, "pre abort");
        exec_instr(SW, 0, 0, 100, 2, er, "sw abort");
        check_count("count after abort");
        exec_instr(ADD, 0, 0, 0, -1, er, "after abort");
    endtask

    task automatic test_random();
        logic [5:0] ops [11] = '{ADD, 6'h0C, 6'h08, BEQZ, BENZ, J, JAL, JALR, JR, SW, LW};
        bit er;
        for (int k = 0; k < 40; k++) begin
            exec_instr(ops[$urandom_range(0, 10)], rbit(), int'($urandom_range(0, TO)),
                       int'($urandom_range(0, TO)), -1, er, $sformatf("rand%0d", k));
        end
        check_count("count after random");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1;
        bus.opcode     = '0;
        bus.condition  = 0;
        bus.imem_ready = 0;
        bus.dmem_ready = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_lw_stall();
        test_branch();
        test_jumps();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
